// File: rtl/iobus_timer_target.sv
// IO bus target exposing a 32-bit down-counter timer as four registers
// (CTRL, LOAD, COUNT, STATUS) with a fixed-latency ready handshake and level irq.
module iobus_timer_target #(
  parameter int unsigned READY_LATENCY = 1,
  parameter logic [31:0] RESET_LOAD    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic        read_strobe,
  input  logic        write_strobe,
  input  logic [3:0]  address,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        irq
);

  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READY_LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        reg_q, reg_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [31:0]       load_q, load_d;
  logic [31:0]       count_q, count_d;
  logic              expired_q, expired_d;
  logic              ready_q, ready_d;
  logic [31:0]       read_data_q, read_data_d;

  logic do_wr, ctrl_wr, load_wr, cnt_wr, sts_clr;

  // Byte-offset bits carry no meaning for word registers.
  logic addr_lo_unused;
  assign addr_lo_unused = ^address[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    reg_d       = reg_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    load_d      = load_q;
    count_d     = count_q;
    expired_d   = expired_q;
    read_data_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          rd_d    = read_strobe;
          wr_d    = write_strobe;
          reg_d   = address[3:2];
          be_d    = byte_enable;
          wdata_d = write_data;
          wait_d  = WAIT_INIT;
          state_d = (WAIT_INIT != '0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Writes commit at the end of the respond cycle; ambiguous accesses do nothing.
    do_wr   = (state_q == ST_RESP) && wr_q && !rd_q;
    ctrl_wr = do_wr && (reg_q == REG_CTRL) && be_q[0];
    load_wr = do_wr && (reg_q == REG_LOAD);
    cnt_wr  = do_wr && (reg_q == REG_COUNT) && (be_q != 4'h0);
    sts_clr = do_wr && (reg_q == REG_STATUS) && be_q[0] && wdata_q[0];

    if (sts_clr) expired_d = 1'b0;

    // Timer step; a bus write to COUNT pre-empts it entirely.
    if (ctrl_q[0] && !cnt_wr) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (ctrl_q[1]) count_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    if (ctrl_wr) ctrl_d  = wdata_q[2:0];
    if (load_wr) load_d  = merge_bytes(load_q, wdata_q, be_q);
    if (cnt_wr)  count_d = merge_bytes(count_q, wdata_q, be_q);

    // Read data is staged so it holds the register values seen during the respond cycle.
    ready_d = (state_d == ST_RESP);
    if (ready_d && rd_d && !wr_d) begin
      case (reg_d)
        REG_CTRL:   read_data_d = {29'b0, ctrl_d};
        REG_LOAD:   read_data_d = load_d;
        REG_COUNT:  read_data_d = count_d;
        REG_STATUS: read_data_d = {31'b0, expired_d};
        default:    read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      reg_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      load_q      <= RESET_LOAD;
      count_q     <= '0;
      expired_q   <= 1'b0;
      ready_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      reg_q       <= reg_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      load_q      <= load_d;
      count_q     <= count_d;
      expired_q   <= expired_d;
      ready_q     <= ready_d;
      read_data_q <= read_data_d;
    end
  end

  assign ready     = ready_q;
  assign read_data = read_data_q;
  assign irq       = expired_q & ctrl_q[2];

endmodule

// File: tb/tb_iobus_timer_target.sv
// Scoreboard bench for iobus_timer_target: two instances (latency 1 and 4),
// a cycle model of the timer predicts every read and the exact ready cycle.
module tb_iobus_timer_target;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] load;
    logic [31:0] count;
    logic        expired;
  } tmr_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  strobe_v;
  logic        rd_s;
  logic        wr_s;
  logic [3:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge_be(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One clock of the timer register file, optionally with a committing bus write.
  function automatic tmr_t tmr_next(input tmr_t s, input logic wr, input logic [1:0] r,
                                    input logic [3:0] b, input logic [31:0] d);
    tmr_t n;
    logic cwr;
    n   = s;
    cwr = wr && (r == 2'd2) && (b != 4'h0);
    if (wr && r == 2'd3 && b[0] && d[0]) n.expired = 1'b0;
    if (s.ctrl[0] && !cwr) begin
      if (s.count != 32'd0) n.count = s.count - 32'd1;
      else begin
        n.expired = 1'b1;
        if (s.ctrl[1]) n.count = s.load;
        else           n.ctrl[0] = 1'b0;
      end
    end
    if (wr && r == 2'd0 && b[0]) n.ctrl = d[2:0];
    if (wr && r == 2'd1) n.load = merge_be(s.load, d, b);
    if (cwr) n.count = merge_be(s.count, d, b);
    return n;
  endfunction

  function automatic logic [31:0] reg_val(input tmr_t s, input logic [1:0] r);
    case (r)
      2'd0:    return {29'b0, s.ctrl};
      2'd1:    return s.load;
      2'd2:    return s.count;
      default: return {31'b0, s.expired};
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int unsigned LAT   = (g == 0) ? 1 : 4;
    localparam logic [31:0] RLOAD = (g == 0) ? 32'h0 : 32'hCAFE_0001;

    logic [31:0] rdata;
    logic        rdy;
    logic        irq_o;
    tmr_t        m;
    exp_t        q[$];
    logic        busy;
    int unsigned cnt;
    logic        a_rd, a_wr;
    logic [1:0]  a_r;
    logic [3:0]  a_be;
    logic [31:0] a_d;
    logic [31:0] cyc = 32'd0;
    logic [31:0] last_rd;

    iobus_timer_target #(.READY_LATENCY(LAT), .RESET_LOAD(RLOAD)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .strobe       (strobe_v[g]),
      .read_strobe  (rd_s),
      .write_strobe (wr_s),
      .address      (addr),
      .byte_enable  (be),
      .write_data   (wdata),
      .read_data    (rdata),
      .ready        (rdy),
      .irq          (irq_o)
    );

    // Model + scoreboard push: an accepted strobe predicts data LAT timer steps ahead.
    always @(posedge clk) begin : model
      tmr_t s;
      exp_t e;
      cyc <= cyc + 32'd1;
      if (rst) begin
        m    <= '{ctrl: 3'b0, load: RLOAD, count: 32'd0, expired: 1'b0};
        busy <= 1'b0;
        cnt  <= 0;
        q.delete();
      end else begin
        m <= tmr_next(m, busy && cnt == 0 && a_wr && !a_rd, a_r, a_be, a_d);
        if (!busy && strobe_v[g]) begin
          busy <= 1'b1;
          cnt  <= LAT - 1;
          a_rd <= rd_s;
          a_wr <= wr_s;
          a_r  <= addr[3:2];
          a_be <= be;
          a_d  <= wdata;
          s = m;
          for (int i = 0; i < int'(LAT); i++) s = tmr_next(s, 1'b0, 2'd0, 4'h0, 32'd0);
          e.cyc  = cyc + LAT;
          e.chk  = !(wr_s && !rd_s);
          e.data = (rd_s && !wr_s) ? reg_val(s, addr[3:2]) : 32'd0;
          q.push_back(e);
        end else if (busy) begin
          if (cnt == 0) busy <= 1'b0;
          else          cnt  <= cnt - 1;
        end
      end
    end

    always @(negedge clk) begin : monitor
      exp_t e;
      check("irq_level", 32'(irq_o), 32'(m.expired & m.ctrl[2]));
      if (rdy) begin
        if (q.size() == 0) check("spurious_ready", 32'(rdy), 32'd0);
        else begin
          e = q.pop_front();
          check("ready_cycle", cyc, e.cyc);
          if (e.chk) check("read_data", rdata, e.data);
          last_rd <= rdata;
        end
      end else begin
        check("idle_read_data", rdata, 32'd0);
      end
    end
  end

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk);
      done = (g_u[0].q.size() == 0) && (g_u[1].q.size() == 0);
    end
    if (!done) begin
      check("drain_timeout", 32'(g_u[0].q.size() + g_u[1].q.size()), 32'd0);
      g_u[0].q.delete();
      g_u[1].q.delete();
    end
  endtask

  task automatic access(input int u, input logic rd, input logic wr, input logic [3:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    strobe_v[u] = 1'b1;
    rd_s = rd; wr_s = wr; addr = a; be = b; wdata = d;
    @(negedge clk);
    strobe_v = 2'b00; rd_s = 1'b0; wr_s = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; strobe_v = 2'b00; rd_s = 1'b0; wr_s = 1'b0;
    addr = 4'h0; be = 4'h0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready0", 32'(g_u[0].rdy), 32'd0);
    check("rst_irq1",   32'(g_u[1].irq_o), 32'd0);

    // Reset values of all four registers at both latencies
    for (int u = 0; u < 2; u++)
      for (int r = 0; r < 4; r++) access(u, 1'b1, 1'b0, 4'(r * 4), 4'hF, 32'd0);
    access(1, 1'b1, 1'b0, 4'h4, 4'hF, 32'd0);
    check("reset_load_u1", g_u[1].last_rd, 32'hCAFE_0001);

    // Auto-reload countdown, then stop and W1C
    access(0, 1'b0, 1'b1, 4'h4, 4'hF, 32'd5);
    access(0, 1'b0, 1'b1, 4'h0, 4'hF, 32'd3);
    for (int i = 0; i < 8; i++) access(0, 1'b1, 1'b0, 4'h8, 4'hF, 32'd0);
    access(0, 1'b1, 1'b0, 4'hC, 4'hF, 32'd0);
    access(0, 1'b0, 1'b1, 4'h0, 4'hF, 32'd0);
    access(0, 1'b0, 1'b1, 4'hC, 4'hF, 32'd1);
    access(0, 1'b1, 1'b0, 4'hF, 4'hF, 32'd0);
    check("w1c_clear", g_u[0].last_rd, 32'd0);

    // One-shot with irq
    access(0, 1'b0, 1'b1, 4'h4, 4'hF, 32'd3);
    access(0, 1'b0, 1'b1, 4'h8, 4'hF, 32'd3);
    access(0, 1'b0, 1'b1, 4'h0, 4'hF, 32'd5);
    repeat (10) @(negedge clk);
    check("oneshot_irq", 32'(g_u[0].irq_o), 32'd1);
    access(0, 1'b1, 1'b0, 4'h0, 4'hF, 32'd0);
    check("oneshot_ctrl", g_u[0].last_rd, 32'd4);
    access(0, 1'b1, 1'b0, 4'h8, 4'hF, 32'd0);
    check("oneshot_count", g_u[0].last_rd, 32'd0);

    // Byte lanes, empty enables, ambiguous accesses
    access(0, 1'b0, 1'b1, 4'h4, 4'hF, 32'd0);
    access(0, 1'b0, 1'b1, 4'h4, 4'b0010, 32'hAABBCCDD);
    access(0, 1'b1, 1'b0, 4'h4, 4'hF, 32'd0);
    check("be_lane1", g_u[0].last_rd, 32'h0000CC00);
    access(0, 1'b0, 1'b1, 4'h4, 4'h0, 32'hFFFFFFFF);
    access(0, 1'b0, 1'b0, 4'h4, 4'hF, 32'h11111111);
    access(0, 1'b1, 1'b1, 4'h4, 4'hF, 32'h22222222);
    access(0, 1'b1, 1'b0, 4'h4, 4'hF, 32'd0);
    check("be_none", g_u[0].last_rd, 32'h0000CC00);
    access(0, 1'b0, 1'b1, 4'h0, 4'hF, 32'hFFFF_FFF8);
    access(0, 1'b1, 1'b0, 4'h0, 4'hF, 32'd0);

    // Latency 4, strobe during a busy access is ignored
    access(1, 1'b1, 1'b0, 4'h4, 4'hF, 32'd0);
    @(negedge clk); strobe_v[1] = 1'b1; rd_s = 1'b1; addr = 4'h8;
    @(negedge clk); strobe_v[1] = 1'b0;
    @(negedge clk); strobe_v[1] = 1'b1;
    @(negedge clk); strobe_v[1] = 1'b0; rd_s = 1'b0;
    drain();
    repeat (8) @(negedge clk);

    // Reset in the middle of a latency-4 write
    @(negedge clk); strobe_v[1] = 1'b1; wr_s = 1'b1; addr = 4'h4; be = 4'hF; wdata = 32'h55;
    @(negedge clk); strobe_v[1] = 1'b0; wr_s = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_drop_q", 32'(g_u[1].q.size()), 32'd0);
    access(1, 1'b1, 1'b0, 4'h4, 4'hF, 32'd0);
    check("rst_no_commit", g_u[1].last_rd, 32'hCAFE_0001);

    // W1C lands in the expiry cycle: set wins
    access(0, 1'b0, 1'b1, 4'h8, 4'hF, 32'd1);
    access(0, 1'b0, 1'b1, 4'h0, 4'hF, 32'd1);
    access(0, 1'b0, 1'b1, 4'hC, 4'hF, 32'd1);
    access(0, 1'b1, 1'b0, 4'hC, 4'hF, 32'd0);
    check("w1c_vs_set", g_u[0].last_rd, 32'd1);

    // COUNT write lands in the expiry cycle: write wins, no expiry
    access(0, 1'b0, 1'b1, 4'h0, 4'hF, 32'd0);
    access(0, 1'b0, 1'b1, 4'hC, 4'hF, 32'd1);
    access(0, 1'b0, 1'b1, 4'h8, 4'hF, 32'd1);
    access(0, 1'b0, 1'b1, 4'h0, 4'hF, 32'd1);
    access(0, 1'b0, 1'b1, 4'h8, 4'hF, 32'd9);
    access(0, 1'b1, 1'b0, 4'h8, 4'hF, 32'd0);
    check("cnt_wr_wins", g_u[0].last_rd, 32'd8);
    access(0, 1'b1, 1'b0, 4'hC, 4'hF, 32'd0);
    check("no_expiry", g_u[0].last_rd, 32'd0);

    // LOAD=0 with auto-reload expires every cycle
    access(0, 1'b0, 1'b1, 4'h4, 4'hF, 32'd0);
    access(0, 1'b0, 1'b1, 4'h0, 4'hF, 32'd7);
    access(0, 1'b0, 1'b1, 4'hC, 4'hF, 32'd1);
    access(0, 1'b1, 1'b0, 4'hC, 4'hF, 32'd0);
    check("load0_reload", g_u[0].last_rd, 32'd1);
    access(0, 1'b1, 1'b0, 4'h8, 4'hF, 32'd0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
